// File: rtl/text_vram_engine.sv
// Character-cell video RAM: one {b,g,r,char} word per screen position, a never-stalled
// display read port, a CPU port with per-field write enables, and a fill / scroll-up engine.
module text_vram_engine #(
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int COLOR_W    = 8,
  parameter int ADDR_WIDTH = 13,
  localparam int CELL_W    = 8 + 3 * COLOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [7:0]            disp_char,
  output logic [COLOR_W-1:0]    disp_r,
  output logic [COLOR_W-1:0]    disp_g,
  output logic [COLOR_W-1:0]    disp_b,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [3:0]            cpu_be,
  input  logic [CELL_W-1:0]     cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_rvalid,
  output logic [CELL_W-1:0]     cpu_rdata,
  input  logic                  cmd_valid,
  input  logic                  cmd_op,
  input  logic [7:0]            cmd_rows,
  input  logic [CELL_W-1:0]     cmd_fill,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int PAGE = COLS * ROWS;
  typedef logic [ADDR_WIDTH:0] idx_t;
  localparam idx_t PAGE_I = idx_t'(PAGE);
  localparam idx_t COLS_I = idx_t'(COLS);
  // Blank cell: space character, white on white.
  localparam logic [CELL_W-1:0] BLANK = {{(3 * COLOR_W){1'b1}}, 8'h20};

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SC_RD, S_SC_WR, S_SC_CLR, S_DONE
  } state_t;

  state_t              state_q;
  idx_t                idx_q, off_q, span_q;
  logic [CELL_W-1:0]   fill_q;
  logic                busy_q, done_q;

  logic [CELL_W-1:0]   mem_q [2**ADDR_WIDTH];
  logic [CELL_W-1:0]   pb_raw_q;
  logic [CELL_W-1:0]   pb_rdata;
  logic [CELL_W-1:0]   disp_q;
  logic [CELL_W-1:0]   cpu_hold_q;
  logic                cpu_rvalid_q, cpu_oor_q;

  logic [3:0]          b_we_d;
  logic                b_re_d;
  idx_t                b_addr_d;
  logic [CELL_W-1:0]   b_wdata_d;
  logic [CELL_W-1:0]   b_wenc;
  logic [ADDR_WIDTH-1:0] b_idx;
  logic                b_in_range;
  logic                cpu_accept;

  assign cmd_ready  = (state_q == S_IDLE);
  assign cpu_ready  = (state_q == S_IDLE) && !cmd_valid;
  assign cpu_accept = cpu_req && cpu_ready;

  // Port B arbitration: the CPU owns it in IDLE, the engine in every other state.
  always_comb begin
    // NOTE: every output gets a default before the case, so no latch is inferred.
    b_we_d    = '0;
    b_re_d    = 1'b0;
    b_addr_d  = {1'b0, cpu_addr};
    b_wdata_d = cpu_wdata;
    case (state_q)
      S_IDLE: begin
        if (cpu_accept) begin
          if (cpu_we) b_we_d = cpu_be;
          else        b_re_d = 1'b1;
        end
      end
      S_FILL, S_SC_CLR: begin
        b_we_d    = 4'hF;
        b_addr_d  = idx_q;
        b_wdata_d = fill_q;
      end
      S_SC_RD: begin
        b_re_d   = 1'b1;
        b_addr_d = idx_q + off_q;
      end
      S_SC_WR: begin
        b_we_d    = 4'hF;
        b_addr_d  = idx_q;
        b_wdata_d = pb_rdata;
      end
      default: ;
    endcase
    if (rst) b_we_d = '0;
  end

  assign b_in_range = (b_addr_d < PAGE_I);
  assign b_idx      = b_addr_d[ADDR_WIDTH-1:0];
  // Cells are stored XOR-ed with BLANK so that zero-initialised RAM powers up as blank cells.
  assign b_wenc     = b_wdata_d ^ BLANK;
  assign pb_rdata   = pb_raw_q ^ BLANK;

  // NOTE: the array has no reset branch; RAM contents survive rst and map onto block RAM.
  always_ff @(posedge clk) begin
    if (b_in_range) begin
      if (b_we_d[0]) mem_q[b_idx][7:0]                    <= b_wenc[7:0];
      if (b_we_d[1]) mem_q[b_idx][8 +: COLOR_W]           <= b_wenc[8 +: COLOR_W];
      if (b_we_d[2]) mem_q[b_idx][8 + COLOR_W +: COLOR_W] <= b_wenc[8 + COLOR_W +: COLOR_W];
      if (b_we_d[3]) mem_q[b_idx][8 + 2*COLOR_W +: COLOR_W] <= b_wenc[8 + 2*COLOR_W +: COLOR_W];
    end
    if (b_re_d) pb_raw_q <= mem_q[b_idx];
  end

  always_ff @(posedge clk) begin
    if (rst)                               disp_q <= '0;
    else if ({1'b0, disp_addr} < PAGE_I) disp_q <= mem_q[disp_addr] ^ BLANK;
    else                                   disp_q <= '0;
  end

  assign disp_char = disp_q[7:0];
  assign disp_r    = disp_q[8 +: COLOR_W];
  assign disp_g    = disp_q[8 + COLOR_W +: COLOR_W];
  assign disp_b    = disp_q[8 + 2*COLOR_W +: COLOR_W];

  // Read data comes straight from the RAM register in the rvalid cycle and is held afterwards.
  assign cpu_rdata  = cpu_rvalid_q ? (cpu_oor_q ? '0 : pb_rdata) : cpu_hold_q;
  assign cpu_rvalid = cpu_rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid_q <= 1'b0;
      cpu_oor_q    <= 1'b0;
      cpu_hold_q   <= '0;
    end else begin
      cpu_rvalid_q <= cpu_accept && !cpu_we;
      if (cpu_accept && !cpu_we) cpu_oor_q <= !b_in_range;
      cpu_hold_q   <= cpu_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      span_q  <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            fill_q <= cmd_fill;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (!cmd_op || int'(cmd_rows) >= ROWS) begin
              state_q <= S_FILL;
            end else if (cmd_rows == 8'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SC_RD;
              off_q   <= idx_t'(cmd_rows) * COLS_I;
              span_q  <= PAGE_I - idx_t'(cmd_rows) * COLS_I;
            end
          end
        end
        S_FILL, S_SC_CLR: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == PAGE_I - 1'b1) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_SC_RD: state_q <= S_SC_WR;
        S_SC_WR: begin
          idx_q   <= idx_q + 1'b1;
          state_q <= (idx_q + 1'b1 == span_q) ? S_SC_CLR : S_SC_RD;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_text_vram_engine.sv
// Bench for text_vram_engine on a 4x3 screen: table-driven CPU/display vectors,
// a read scoreboard against a reference cell array, and command timing sequences.
module tb_text_vram_engine;

  localparam int COLS = 4, ROWS = 3, COLOR_W = 8, AW = 4, CW = 32;
  localparam int PAGE = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] disp_addr = '0;
  logic [7:0]    disp_char;
  logic [7:0]    disp_r, disp_g, disp_b;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [3:0]    cpu_be = '0;
  logic [CW-1:0] cpu_wdata = '0;
  logic          cpu_ready, cpu_rvalid;
  logic [CW-1:0] cpu_rdata;
  logic          cmd_valid = 1'b0, cmd_op = 1'b0;
  logic [7:0]    cmd_rows = '0;
  logic [CW-1:0] cmd_fill = '0;
  logic          cmd_ready, busy, done;

  text_vram_engine #(.COLS(COLS), .ROWS(ROWS), .COLOR_W(COLOR_W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .disp_addr(disp_addr), .disp_char(disp_char), .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_rows(cmd_rows), .cmd_fill(cmd_fill),
    .cmd_ready(cmd_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [CW-1:0] model [PAGE];

  typedef struct { string name; logic [CW-1:0] exp; } sb_t;
  sb_t sb[$];

  typedef enum { V_WR, V_RD, V_DISP } kind_t;
  typedef struct { kind_t kind; logic [AW-1:0] addr; logic [3:0] be; logic [CW-1:0] data; } vec_t;
  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Read-data monitor: every rvalid pulse consumes the oldest pending expectation.
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow: rvalid with no pending read");
      end else begin
        sb_t e;
        e = sb.pop_front();
        check(e.name, cpu_rdata, e.exp);
      end
    end
  end

  task automatic wait_cpu_ready();
    int n = 0;
    while (!cpu_ready && n < 50) begin
      tick();
      n++;
    end
    check("cpu_ready_wait", {31'd0, cpu_ready}, 32'd1);
  endtask

  task automatic cpu_write(input logic [AW-1:0] addr, input logic [3:0] be, input logic [CW-1:0] data);
    logic [CW-1:0] mask;
    wait_cpu_ready();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_be = be; cpu_wdata = data;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (int'(addr) < PAGE) model[addr] = (model[addr] & ~mask) | (data & mask);
  endtask

  task automatic cpu_read(input logic [AW-1:0] addr, input logic [CW-1:0] exp, input string name);
    wait_cpu_ready();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    sb.push_back('{name, exp});
    tick();
    cpu_req = 1'b0;
    check({name, "_rvalid"}, {31'd0, cpu_rvalid}, 32'd1);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < PAGE; i++) cpu_read(AW'(i), model[i], $sformatf("%s_cell%0d", tag, i));
  endtask

  // Issues one command, then times busy/done and watches display cell 0 while busy.
  task automatic run_cmd(input logic op, input logic [7:0] rows, input logic [CW-1:0] fill,
                         input int exp_cycles, input string tag,
                         output logic [7:0] first_char, output logic [7:0] last_char);
    int done_at = -1;
    int busy_n = 0;
    int rdy_bad = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_rows = rows; cmd_fill = fill; disp_addr = '0;
    #1;
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0; cmd_op = ~op; cmd_rows = 8'd0; cmd_fill = 32'hDEAD_BEEF;
    first_char = disp_char;
    last_char  = disp_char;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (busy) busy_n++;
      if (busy && cpu_ready) rdy_bad++;
      last_char = disp_char;
      if (done) begin
        done_at = cyc;
        break;
      end
      tick();
    end
    check({tag, "_done_cycle"}, done_at, exp_cycles);
    check({tag, "_busy_cycles"}, busy_n, exp_cycles);
    check({tag, "_cpu_ready_while_busy"}, rdy_bad, 0);
    tick();
    check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [7:0] fc, lc;

    vecs[0]  = '{V_DISP, 4'd5,  4'h0, 32'hFFFF_FF20};
    vecs[1]  = '{V_DISP, 4'd12, 4'h0, 32'h0000_0000};
    vecs[2]  = '{V_WR,   4'd7,  4'h3, 32'h3322_1141};
    vecs[3]  = '{V_RD,   4'd7,  4'h0, 32'hFFFF_1141};
    vecs[4]  = '{V_WR,   4'd12, 4'hF, 32'h1234_5678};
    vecs[5]  = '{V_WR,   4'd3,  4'h0, 32'hDEAD_BEEF};
    vecs[6]  = '{V_RD,   4'd3,  4'h0, 32'hFFFF_FF20};
    vecs[7]  = '{V_RD,   4'd12, 4'h0, 32'h0000_0000};
    vecs[8]  = '{V_WR,   4'd0,  4'hC, 32'hAABB_CCDD};
    vecs[9]  = '{V_RD,   4'd0,  4'h0, 32'hAABB_FF20};
    vecs[10] = '{V_DISP, 4'd7,  4'h0, 32'hFFFF_1141};
    vecs[11] = '{V_WR,   4'd11, 4'hF, 32'h0102_0304};
    vecs[12] = '{V_DISP, 4'd11, 4'h0, 32'h0102_0304};
    vecs[13] = '{V_RD,   4'd11, 4'h0, 32'h0102_0304};
    for (int i = 0; i < PAGE; i++) model[i] = 32'hFFFF_FF20;

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_disp", {disp_b, disp_g, disp_r, disp_char}, 32'd0);
    check("rst_readies", {30'd0, cmd_ready, cpu_ready}, 32'd3);
    rst = 1'b0;
    tick();

    // Power-up contents, field enables, out-of-range accesses.
    foreach (vecs[i]) begin
      case (vecs[i].kind)
        V_WR: cpu_write(vecs[i].addr, vecs[i].be, vecs[i].data);
        V_RD: cpu_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d_rdata", i));
        default: begin
          disp_addr = vecs[i].addr;
          tick();
          check($sformatf("vec%0d_disp", i), {disp_b, disp_g, disp_r, disp_char}, vecs[i].data);
        end
      endcase
    end
    repeat (2) tick();
    check("rdata_hold", cpu_rdata, 32'h0102_0304);
    sweep("pwr");

    // FILL.
    run_cmd(1'b0, 8'd0, 32'h0000_002E, PAGE + 1, "fill", fc, lc);
    check("fill_disp_first", {24'd0, fc}, 32'h20);
    check("fill_disp_last", {24'd0, lc}, 32'h2E);
    for (int i = 0; i < PAGE; i++) model[i] = 32'h0000_002E;
    sweep("fill");

    // SCROLL_UP by one row.
    for (int i = 0; i < PAGE; i++) cpu_write(AW'(i), 4'h1, 32'h41 + i);
    run_cmd(1'b1, 8'd1, 32'h0000_0020, 2 * 8 + 4 + 1, "scroll1", fc, lc);
    check("scroll1_disp_first", {24'd0, fc}, 32'h41);
    check("scroll1_disp_last", {24'd0, lc}, 32'h45);
    for (int d = 0; d < PAGE - COLS; d++) model[d] = model[d + COLS];
    for (int d = PAGE - COLS; d < PAGE; d++) model[d] = 32'h0000_0020;
    sweep("scroll1");

    // SCROLL_UP by zero rows, then by more rows than the screen holds.
    run_cmd(1'b1, 8'd0, 32'h1234_5678, 1, "scroll0", fc, lc);
    sweep("scroll0");
    run_cmd(1'b1, 8'd5, 32'h1122_3344, PAGE + 1, "scroll5", fc, lc);
    for (int i = 0; i < PAGE; i++) model[i] = 32'h1122_3344;
    sweep("scroll5");

    // Command wins over a same-cycle CPU write; reset five cycles into a FILL.
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_rows = 8'd0; cmd_fill = 32'h5555_5555;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd4; cpu_be = 4'hF; cpu_wdata = 32'h9999_9999;
    #1;
    check("prio_readies", {30'd0, cmd_ready, cpu_ready}, 32'd2);
    tick();
    cmd_valid = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    check("prio_busy", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy_done", {30'd0, busy, done}, 32'd0);
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_rdata", cpu_rdata, 32'd0);
    check("abort_disp", {disp_b, disp_g, disp_r, disp_char}, 32'd0);
    for (int i = 0; i < 4; i++) model[i] = 32'h5555_5555;
    sweep("abort");

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
